// File: rtl/led_bar_sched.sv
// led_bar_sched: round-robin scheduler sharing a 30-LED level bar among four sources, with a fading peak marker
module led_bar_sched #(
  parameter int DWELL = 1024,
  parameter int FADE_STEP = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [23:0] level,
  input  logic        lock,
  output logic [3:0]  grant,
  output logic [1:0]  sel,
  output logic        valid,
  output logic [29:0] lights
);
  typedef enum logic [1:0] {IDLE, SHOW, SWITCH} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, sel_n, win;
  logic [15:0] cnt, cnt_n, fc, fc_n, fb;
  logic [4:0] p, p_n, pb, b;
  logic [5:0] lvl;
  logic [3:0] grant_n;
  logic [29:0] lights_n;
  logic valid_n, entering, stay, expire;
  // Registers every piece of state and every output; reset returns everything to zero except ptr, which parks at 3 so source 0 wins first
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr <= 2'd3;
      sel <= '0;
      grant <= '0;
      valid <= 1'b0;
      lights <= '0;
      cnt <= '0;
      fc <= '0;
      p <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      sel <= sel_n;
      grant <= grant_n;
      valid <= valid_n;
      lights <= lights_n;
      cnt <= cnt_n;
      fc <= fc_n;
      p <= p_n;
    end
  end
  // Next-state, rotation, dwell, peak tracking and the next registered outputs
  always_comb begin
    win = ptr;
    for (int k = 4; k >= 1; k--) if (req[ptr + 2'(k)]) win = ptr + 2'(k);
    state_n = state;
    ptr_n = ptr;
    sel_n = sel;
    cnt_n = '0;
    fc_n = '0;
    p_n = '0;
    entering = 1'b0;
    stay = 1'b0;
    expire = !lock && cnt == 16'(DWELL - 1);
    case (state)
      IDLE: if (|req) begin state_n = SHOW; entering = 1'b1; end
      SHOW: begin
        if (!req[sel] || (expire && |(req & ~grant))) state_n = SWITCH;
        else begin
          stay = 1'b1;
          cnt_n = expire ? 16'd0 : lock ? cnt : cnt + 16'd1;
        end
      end
      default: begin
        state_n = |req ? SHOW : IDLE;
        entering = |req;
      end
    endcase
    if (entering) begin
      sel_n = win;
      ptr_n = win;
    end
    if (state_n == IDLE) sel_n = '0;
    lvl = 6'(level >> (6 * sel_n));
    b = lvl > 6'd30 ? 5'd30 : lvl[4:0];
    pb = entering ? 5'd0 : p;
    fb = entering ? 16'd0 : fc;
    if (entering || stay) begin
      if (b > pb) begin
        p_n = b;
        fc_n = '0;
      end else begin
        fc_n = fb == 16'(FADE_STEP - 1) ? 16'd0 : fb + 16'd1;
        p_n = (fb == 16'(FADE_STEP - 1) && pb != 5'd0) ? pb - 5'd1 : pb;
      end
    end
    valid_n = state_n == SHOW;
    grant_n = valid_n ? 4'd1 << sel_n : 4'd0;
    lights_n = valid_n ? (((30'd1 << b) - 30'd1) | (p_n != 5'd0 ? 30'd1 << (p_n - 5'd1) : 30'd0)) : 30'd0;
  end
endmodule

// File: tb/tb_led_bar_sched.sv
// tb_led_bar_sched: randomized and directed stimulus checked cycle by cycle against a behavioural model
module tb_led_bar_sched;
  localparam int DW = 8;
  localparam int FS = 4;
  logic clock = 0, reset = 1, lock = 0;
  logic [3:0] req = 0;
  logic [23:0] level = 0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic valid;
  logic [29:0] lights;
  int errors = 0, checks = 0;
  int m_st = 0, m_own = 0, m_ptr = 3, m_cnt = 0, m_pk = 0, m_fd = 0;
  int e_grant = 0, e_sel = 0, e_valid = 0, e_lights = 0;

  led_bar_sched #(.DWELL(DW), .FADE_STEP(FS)) dut (
    .clock(clock), .reset(reset), .req(req), .level(level), .lock(lock),
    .grant(grant), .sel(sel), .valid(valid), .lights(lights)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lvl_of(int i);
    int v = int'((level >> (6 * i)) & 24'h3F);
    return v > 30 ? 30 : v;
  endfunction

  task automatic peak_step();
    int b = lvl_of(m_own);
    if (b > m_pk) begin
      m_pk = b;
      m_fd = 0;
    end else begin
      m_fd = (m_fd + 1) % FS;
      if (m_fd == 0 && m_pk > 0) m_pk--;
    end
    e_lights = ((1 << b) - 1) | (m_pk > 0 ? 1 << (m_pk - 1) : 0);
  endtask

  task automatic enter_show();
    for (int k = 1; k <= 4; k++)
      if (req[(m_ptr + k) % 4]) begin
        m_own = (m_ptr + k) % 4;
        break;
      end
    m_ptr = m_own;
    m_cnt = 0;
    m_pk = 0;
    m_fd = 0;
    m_st = 1;
    peak_step();
  endtask

  task automatic model_step();
    if (reset) begin
      m_st = 0;
      m_ptr = 3;
    end else if (m_st == 0) begin
      if (req != 0) enter_show();
    end else if (m_st == 1) begin
      if (!req[m_own] || (!lock && m_cnt == DW - 1 && (req & ~(4'd1 << m_own)) != 0)) m_st = 2;
      else begin
        if (!lock) m_cnt = (m_cnt + 1) % DW;
        peak_step();
      end
    end else if (req != 0) enter_show();
    else m_st = 0;
    e_grant = m_st == 1 ? 1 << m_own : 0;
    e_sel = m_st == 0 ? 0 : m_own;
    e_valid = m_st == 1 ? 1 : 0;
    if (m_st != 1) e_lights = 0;
  endtask

  task automatic cyc(input logic r, input logic [3:0] rq, input logic [23:0] lv, input logic lk, input int n);
    for (int i = 0; i < n; i++) begin
      reset = r;
      req = rq;
      level = lv;
      lock = lk;
      @(posedge clock);
      model_step();
      #1;
      check("grant", 32'(grant), 32'(e_grant));
      check("sel", 32'(sel), 32'(e_sel));
      check("valid", 32'(valid), 32'(e_valid));
      check("lights", 32'(lights), 32'(e_lights));
    end
  endtask

  initial begin
    cyc(1, 0, 0, 0, 2);
    check("reset_lights", 32'(lights), 32'h0);
    check("reset_grant", 32'(grant), 32'h0);
    cyc(0, 4'b0101, {6'd0, 6'd20, 6'd0, 6'd10}, 0, 40);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 4'b0001, 24'd12, 0, 10);
    check("bar12", 32'(lights), 32'h0FFF);
    cyc(0, 4'b0001, 24'd3, 0, 50);
    cyc(0, 4'b0001, 24'd45, 0, 3);
    check("bar_clamp", 32'(lights), 32'h3FFFFFFF);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 4'b0001, 24'd0, 0, 3);
    check("bar_zero", 32'(lights), 32'h0);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 4'b0011, 24'h0_0A5, 1, 20);
    check("lock_hold", 32'(grant), 32'h1);
    cyc(0, 4'b0010, 24'h0_0A5, 1, 3);
    cyc(0, 4'b1111, 24'hFFF_FFF, 0, 5);
    cyc(1, 4'b1111, 24'hFFF_FFF, 0, 1);
    check("reset_mid_show", 32'({grant, sel, valid, lights}), 32'h0);
    cyc(0, 4'b1000, 24'hFC0_000, 0, 3);
    check("after_reset_grant", 32'(grant), 32'h8);
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] rq = req;
      logic [23:0] lv = level;
      if ($urandom_range(7) == 0) rq = 4'($urandom);
      if ($urandom_range(3) == 0) lv = 24'($urandom);
      cyc($urandom_range(199) == 0, rq, lv, $urandom_range(5) == 0, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_bar_sched.md
LED_BAR_SCHED -- requirements
Module: led_bar_sched

Interface
REQ-001 Parameter DWELL, default 1024, SHOW cycles granted per source before rotation (range 2..65535).
REQ-002 Parameter FADE_STEP, default 64, cycles between peak-marker decrements (range 2..65535).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req  input  4  req[i]=1: source i requests the bar.
REQ-006 level  input  24  packed 6-bit levels; source i on level[6i+5:6i]; unsigned.
REQ-007 lock  input  1  freezes the dwell counter while 1.
REQ-008 grant  output  4  one-hot current owner; 0 when none.
REQ-009 sel  output  2  index of current/last owner.
REQ-010 valid  output  1  1 only while lights show owner data.
REQ-011 lights  output  30  registered bar pattern; bit 0 = bottom LED.

Function
REQ-012 States IDLE, SHOW, SWITCH; only IDLE->SHOW, SHOW->SWITCH, SWITCH->SHOW, SWITCH->IDLE; all outputs registered.
REQ-013 Round-robin pointer ptr (2 bits) holds last owner; winner is first i with req[i]=1 searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-014 IDLE: if req!=0, next cycle SHOW with grant=onehot(winner), sel=winner, ptr=winner, dwell count=0; else stay IDLE, outputs at reset values.
REQ-015 SHOW: dwell count increments by 1 per cycle unless lock=1 (hold).
REQ-016 SHOW, count==DWELL-1, no req outside sel: count wraps to 0, stay SHOW, no visible change.
REQ-017 SHOW, count==DWELL-1, another req set: next cycle SWITCH.
REQ-018 SHOW, req[sel]=0 sampled: next cycle SWITCH, regardless of lock or count; takes precedence over REQ-016/017.
REQ-019 SWITCH lasts exactly 1 cycle: grant=0, valid=0, lights=0; then SHOW with new winner per REQ-013/014 if req!=0, else IDLE.
REQ-020 Bar length B = min(level[sel], 30); bar bits [B-1:0]=1, rest 0; level 0 gives no bar; 31..63 clamp to 30.
REQ-021 lights in SHOW = bar OR peak marker (bit P-1 when P>0), based on level sampled previous cycle (1-cycle latency); valid=1.
REQ-022 Peak P (5 bits, 0..30): cleared to 0 and fade count cleared on every entry to SHOW.
REQ-023 Each SHOW cycle: if B>P then P=B and fade count=0; else fade count increments, and at FADE_STEP-1 wraps to 0 and P decrements if P>0.
REQ-024 lock does not affect peak tracking, fading, or REQ-018.
REQ-025 req changes for non-owners during SHOW affect only the next rotation decision; no preemption.
REQ-026 First grant after reset goes to lowest-index requester (ptr resets to 3).

Reset
REQ-027 reset=1 at any clock edge, in any state (including mid-SHOW or SWITCH), gives next cycle: state IDLE, grant=0, sel=0, valid=0, lights=0, ptr=3, dwell count=0, fade count=0, P=0.
REQ-028 reset dominates all other inputs in the same cycle.

Verification (DWELL=8, FADE_STEP=4)
REQ-029 req=0101, constant levels 10/20: grant 0001 for 8 cycles, one SWITCH cycle with lights=0, then 0100 for 8 cycles, then back to 0001.
REQ-030 Source 0 alone, level=12 then 3 held: lights=0x0FFF; after drop, bar=0x7 with marker at bit 11, marker falls 1 bit every 4 cycles until it merges into bar.
REQ-031 level=45 on owner -> lights=0x3FFFFFFF; level=0 with P=0 -> lights=0.
REQ-032 req=0011, lock=1 held 20 cycles: grant stays 0001; deassert req[0] mid-lock -> SWITCH next cycle, then grant 0010.
REQ-033 Reset asserted during SHOW with lights nonzero -> next cycle all outputs 0; release with req=1000 -> grant 1000 after IDLE cycle.
REQ-034 Only owner present, count reaches 7: no SWITCH, lights continuous, valid stays 1.
